// File: rtl/limbus_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : limbus_pio_pkg
// Description : Shared definitions for the Limbus input PIO. Holds the
//               register word addresses and the debounce counter sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package limbus_pio_pkg;

  // Avalon word addresses of the register file
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_EDGE_POL = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_IRQ_TYPE = 3'd4;
  localparam logic [2:0] ADDR_ANY_EDGE = 3'd5;

  // Number of bits needed to hold max_count (ceil(log2(max_count+1))), at
  // least 1. The debounce limit is capped at 65535, so 17 iterations suffice.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 17; i++) begin
      if (max_count >= (32'd1 << i)) w = i + 1;
    end
    return w;
  endfunction

endpackage : limbus_pio_pkg
`default_nettype wire

// File: rtl/limbus_pio_bit_filter.sv
`default_nettype none
// ============================================================================
// Module      : limbus_pio_bit_filter
// Description : One input pin: synchroniser chain, optional debounce filter
//               and a one-cycle-delayed copy of the filtered value for edge
//               detection.
// Revision    : 1.0 - initial release
// ============================================================================
module limbus_pio_bit_filter
  import limbus_pio_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic filt_o,
  output logic prev_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   filt;
  logic                   prev_q;

  // Shift the asynchronous pin through the synchroniser flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYC == 0) begin : g_bypass
      // No filter: the synchroniser output is the filtered value directly,
      // which keeps the edge path one cycle shorter.
      assign filt = sync_out;
    end else begin : g_debounce
      localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYC);
      localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          filt_q;
      logic          filt_d;

      // Count consecutive disagreeing cycles; accept the new level on the
      // DEBOUNCE_CYC-th one. Any agreeing cycle restarts the count.
      always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_out != filt_q) begin
          if (cnt_q == CNT_LAST) filt_d = sync_out;
          else                   cnt_d  = cnt_q + 1'b1;
        end
      end

      // Debounce counter and filtered-value registers
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign filt = filt_q;
    end
  endgenerate

  // Remember last cycle's filtered value for rise/fall detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= 1'b0;
    else          prev_q <= filt;
  end

  assign filt_o = filt;
  assign prev_o = prev_q;

endmodule : limbus_pio_bit_filter
`default_nettype wire

// File: rtl/limbus_pio_in_irq.sv
`default_nettype none
// ============================================================================
// Module      : limbus_pio_in_irq
// Description : Avalon-MM input PIO with per-bit edge/level interrupt
//               generation and a single registered irq output.
// Revision    : 1.0 - initial release
// ============================================================================
module limbus_pio_in_irq
  import limbus_pio_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] irq_src;
  logic [WIDTH-1:0] rd_sel;
  logic             wr_en;

  logic [WIDTH-1:0] edge_pol_q;
  logic [WIDTH-1:0] irq_mask_q;
  logic [WIDTH-1:0] edge_cap_q;
  logic [WIDTH-1:0] edge_cap_d;
  logic [WIDTH-1:0] irq_type_q;
  logic [WIDTH-1:0] any_edge_q;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             irq_q;
  logic             irq_d;

  generate
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      limbus_pio_bit_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .pin_i   (in_port[b]),
        .filt_o  (filt[b]),
        .prev_o  (prev[b])
      );
    end

    if (WIDTH < 32) begin : g_wdata_hi
      // Upper write-data bits have no register behind them
      logic unused_wdata_hi;
      assign unused_wdata_hi = |writedata[31:WIDTH];
    end
  endgenerate

  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];

  assign rise = filt & ~prev;
  assign fall = ~filt & prev;
  assign sel  = (any_edge_q & (rise | fall)) |
                (~any_edge_q & ((edge_pol_q & rise) | (~edge_pol_q & fall)));

  // Write-one-to-clear, with a same-cycle new edge taking priority
  always_comb begin
    cap_clr    = '0;
    if (wr_en && (address == ADDR_EDGE_CAP)) cap_clr = wdata;
    edge_cap_d = (edge_cap_q & ~cap_clr) | sel;
  end

  // Per-bit source is the sticky capture for edge bits, the live pin otherwise
  always_comb begin
    irq_src = (irq_type_q & edge_cap_q) | (~irq_type_q & filt);
    irq_d   = |(irq_src & irq_mask_q);
  end

  // Read mux from the address presented this cycle; unused upper bits are 0
  always_comb begin
    rd_sel = '0;
    case (address)
      ADDR_DATA:     rd_sel = filt;
      ADDR_EDGE_POL: rd_sel = edge_pol_q;
      ADDR_IRQ_MASK: rd_sel = irq_mask_q;
      ADDR_EDGE_CAP: rd_sel = edge_cap_q;
      ADDR_IRQ_TYPE: rd_sel = irq_type_q;
      ADDR_ANY_EDGE: rd_sel = any_edge_q;
      default:       rd_sel = '0;
    endcase
    readdata_d              = '0;
    readdata_d[WIDTH-1:0]   = rd_sel;
  end

  // Configuration registers, capture register, read data and irq flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_pol_q <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      irq_type_q <= '0;
      any_edge_q <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (address)
          ADDR_EDGE_POL: edge_pol_q <= wdata;
          ADDR_IRQ_MASK: irq_mask_q <= wdata;
          ADDR_IRQ_TYPE: irq_type_q <= wdata;
          ADDR_ANY_EDGE: any_edge_q <= wdata;
          default:       ;
        endcase
      end
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule : limbus_pio_in_irq
`default_nettype wire

// File: tb/tb_limbus_pio_in_irq.sv
`default_nettype none
// ============================================================================
// Module      : tb_limbus_pio_in_irq
// Description : Scoreboard bench for limbus_pio_in_irq. One instance without
//               debounce, one with DEBOUNCE_CYC=4 sharing the write bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_limbus_pio_in_irq;

  localparam int K_RD   = 0;
  localparam int K_IRQ  = 1;
  localparam int K_RDB  = 2;
  localparam int K_IRQB = 3;

  typedef struct {
    int          kind;
    logic [31:0] val;
    int          cyc;
    string       name;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic [2:0]  address_db;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] readdata_db;
  logic [7:0]  in_port;
  logic [7:0]  in_db;
  logic        irq;
  logic        irq_db;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  bit   done   = 1'b0;

  limbus_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYC(0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  limbus_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYC(4)) dut_db (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address_db),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata_db),
    .in_port    (in_db),
    .irq        (irq_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after the n-th rising edge cyc == n
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_exp(input int kind, input logic [31:0] val,
                                   input int at, input string name);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    e.name = name;
    sb.push_back(e);
  endfunction

  // Monitor: compare every expectation scheduled for the current cycle
  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        case (sb[i].kind)
          K_RD:    act = readdata;
          K_IRQ:   act = {31'b0, irq};
          K_RDB:   act = readdata_db;
          default: act = {31'b0, irq_db};
        endcase
        n_vec++;
        if (sb[i].cyc < cyc || act !== sb[i].val) begin
          n_err++;
          $display("FAIL %s cyc=%0d actual=%h required=%h (due cyc %0d)",
                   sb[i].name, cyc, act, sb[i].val, sb[i].cyc);
        end
        sb.delete(i);
      end
    end
    if (done && sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain actual=%0d required=0 entries left", sb.size());
      sb.delete();
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] v, input string name);
    address = a;
    push_exp(K_RD, v, cyc + 1, name);
    step(1);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    address_db = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'h00;
    in_db      = 8'h00;
    step(2);

    // Reset state
    push_exp(K_RD,  32'h0, cyc, "reset_readdata");
    push_exp(K_IRQ, 32'h0, cyc, "reset_irq");
    push_exp(K_RDB, 32'h0, cyc, "reset_readdata_db");
    reset_n = 1'b1;
    step(1);

    // Rising edge on bit 0: capture at edge 3, irq at edge 4, then W1C
    wr(3'd4, 32'hFF);
    wr(3'd1, 32'hFF);
    wr(3'd2, 32'h01);
    address = 3'd3;
    in_port = 8'h01;
    push_exp(K_RD,  32'h00, cyc + 3, "cap0_edge3_pre");
    push_exp(K_IRQ, 32'h0,  cyc + 3, "irq0_edge3");
    push_exp(K_RD,  32'h01, cyc + 4, "cap0_set");
    push_exp(K_IRQ, 32'h1,  cyc + 4, "irq0_edge4");
    step(4);
    push_exp(K_RD,  32'h01, cyc + 1, "cap0_before_clr");
    push_exp(K_IRQ, 32'h1,  cyc + 1, "irq0_at_clr");
    push_exp(K_RD,  32'h00, cyc + 2, "cap0_cleared");
    push_exp(K_IRQ, 32'h0,  cyc + 2, "irq0_after_clr");
    wr(3'd3, 32'h01);
    step(1);

    // Any-edge on bit 4, falling-only on bit 5, bit 0 falls with rising polarity
    wr(3'd5, 32'h10);
    wr(3'd1, 32'hDF);
    address = 3'd3;
    in_port = 8'h10;
    push_exp(K_RD, 32'h00, cyc + 3, "any_rise_pre");
    push_exp(K_RD, 32'h10, cyc + 4, "any_rise_cap");
    step(4);
    push_exp(K_RD, 32'h10, cyc + 1, "any_rise_hold");
    wr(3'd3, 32'hFF);
    in_port = 8'h20;
    push_exp(K_RD, 32'h00, cyc + 1, "any_cleared");
    push_exp(K_RD, 32'h10, cyc + 4, "any_fall_no_b5_rise");
    step(4);
    wr(3'd3, 32'hFF);
    in_port = 8'h00;
    push_exp(K_RD,  32'h20, cyc + 4, "b5_fall_cap");
    push_exp(K_IRQ, 32'h0,  cyc + 4, "b5_masked_irq");
    step(4);

    // Register readback and reserved addresses
    rd(3'd5, 32'h10, "rb_any_edge");
    rd(3'd1, 32'hDF, "rb_edge_pol");
    wr(3'd6, 32'hFF);
    rd(3'd6, 32'h00, "rb_addr6");
    rd(3'd7, 32'h00, "rb_addr7");
    wr(3'd2, 32'hFFFF_FF01);
    rd(3'd2, 32'h01, "rb_mask_upper_ignored");

    // Config changes leave EDGE_CAP untouched; then level mode on bit 7
    wr(3'd4, 32'h00);
    wr(3'd5, 32'h00);
    wr(3'd1, 32'h00);
    wr(3'd2, 32'h80);
    rd(3'd3, 32'h20, "cap_kept_after_cfg");
    address = 3'd3;
    in_port = 8'h80;
    push_exp(K_IRQ, 32'h0, cyc + 1, "lvl_irq_early");
    push_exp(K_IRQ, 32'h1, cyc + 4, "lvl_irq_high");
    step(4);
    in_port = 8'h00;
    push_exp(K_IRQ, 32'h1,  cyc + 2, "lvl_irq_still_high");
    push_exp(K_IRQ, 32'h0,  cyc + 4, "lvl_irq_drop");
    push_exp(K_RD,  32'hA0, cyc + 4, "b7_fall_cap_pol0");
    step(4);
    wr(3'd3, 32'hFF);

    // Set wins over a same-cycle W1C on bit 2
    wr(3'd4, 32'hFF);
    wr(3'd1, 32'hFF);
    wr(3'd2, 32'h04);
    address = 3'd3;
    in_port = 8'h04;
    push_exp(K_RD,  32'h04, cyc + 4, "simul_cap_kept");
    push_exp(K_IRQ, 32'h1,  cyc + 4, "simul_irq");
    push_exp(K_RD,  32'h04, cyc + 5, "simul_cap_hold");
    push_exp(K_IRQ, 32'h1,  cyc + 5, "simul_irq_hold");
    step(2);
    wr(3'd3, 32'h04);
    step(3);
    in_port = 8'h00;
    push_exp(K_IRQ, 32'h0, cyc + 2, "simul_irq_cleared");
    wr(3'd3, 32'hFF);
    step(2);

    // Debounce 4: a 3-cycle glitch is rejected, a 10-cycle pulse passes
    address_db = 3'd0;
    in_db = 8'h01;
    push_exp(K_RDB, 32'h0, cyc + 5, "glitch_data_a");
    push_exp(K_RDB, 32'h0, cyc + 7, "glitch_data_b");
    push_exp(K_RDB, 32'h0, cyc + 9, "glitch_data_c");
    step(3);
    in_db = 8'h00;
    step(8);
    in_db = 8'h01;
    push_exp(K_RDB, 32'h0, cyc + 6, "pulse_rise_pre");
    push_exp(K_RDB, 32'h1, cyc + 7, "pulse_rise_data");
    step(10);
    in_db = 8'h00;
    push_exp(K_RDB, 32'h1, cyc + 6, "pulse_fall_pre");
    push_exp(K_RDB, 32'h0, cyc + 7, "pulse_fall_data");
    step(8);

    // Reset in the middle of a debounce window, pin held high throughout
    address = 3'd2;
    in_db   = 8'h01;
    push_exp(K_RD, 32'h04, cyc + 3, "mask_before_reset");
    step(4);
    reset_n = 1'b0;
    push_exp(K_RD,   32'h0, cyc,     "midrst_readdata");
    push_exp(K_IRQ,  32'h0, cyc,     "midrst_irq");
    push_exp(K_RDB,  32'h0, cyc,     "midrst_readdata_db");
    push_exp(K_IRQB, 32'h0, cyc,     "midrst_irq_db");
    push_exp(K_RDB,  32'h0, cyc + 1, "midrst_hold_db");
    step(1);
    reset_n = 1'b1;
    push_exp(K_RD,  32'h0, cyc + 1, "mask_after_reset");
    push_exp(K_RDB, 32'h0, cyc + 6, "refilter_pre");
    push_exp(K_RDB, 32'h1, cyc + 7, "refilter_data");
    step(9);

    done = 1'b1;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_limbus_pio_in_irq
`default_nettype wire
